seq_xor_engine: RTL and testbench
=================================

SEQ_XOR_ENGINE -- requirements
Module: seq_xor_engine

Interface
Parameters:
REQ-001 AW, 3, bank address width.
REQ-002 LW, 10, polynomial length field width.
REQ-003 WORD_W, 256, bits per memory word; power of two.
REQ-004 MAX_WORDS, 3, word-count cap; 1..2**AW-1.
REQ-005 CMD_CODE, 4'h6, opcode that starts an XOR pass.
REQ-006 SEL_CODE, 3'h5, datapath mux code driven on select_line while active.

Ports:
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 command  in  4  opcode bus, sampled every edge.
REQ-010 start_addr  in  AW  base address; word k lives at start_addr-1-k.
REQ-011 Data_len_Polynomial  in  LW  polynomial length in bits.
REQ-012 b_adbus_A, b_adbus_B  out  AW  operand read addresses, identical values.
REQ-013 b_w_C, b_w_D  out  1  write strobes, result ports C/D.
REQ-014 b_adbus_C, b_adbus_D  out  AW  write addresses.
REQ-015 select_line  out  3  datapath mux select.
REQ-016 cmd_Xor  out  1  bus ownership / busy.
REQ-017 interupt_Xor  out  1  one-cycle completion pulse.
REQ-018 err_Xor  out  1  one-cycle reject pulse.

Function
REQ-019 States IDLE, READ, DONE, RELEASE; nwords = min(Data_len_Polynomial/WORD_W + 1, MAX_WORDS), computed from inputs sampled at the accepting edge and held internally.
REQ-020 In IDLE, command==CMD_CODE at edge E0 with start_addr >= nwords: latch start_addr and nwords; enter READ; cmd_Xor=1; A/B=start_addr-1; select_line=SEL_CODE.
REQ-021 In IDLE, command==CMD_CODE with start_addr < nwords: err_Xor=1 for one cycle; stay IDLE; no other output changes.
REQ-022 Word k is read at edge E(1+k) and written at edge E(2+k): one-cycle read latency, reads and writes pipelined.
REQ-023 At edge E(2+k): even k drives b_w_C=1, b_w_D=0, b_adbus_C=start-1-k; odd k drives b_w_D=1, b_w_C=0, b_adbus_D=start-1-k; the inactive port's address holds.
REQ-024 At edge E(2+k) with k<nwords-1: A/B=start-2-k. After the last read, A/B hold.
REQ-025 Last write edge E(1+nwords): interupt_Xor=1 coincident with the final strobe; enter DONE.
REQ-026 DONE, next edge: both strobes 0; interupt_Xor 0; enter RELEASE.
REQ-027 RELEASE, next edge: cmd_Xor=0; enter IDLE; select_line holds its value.
REQ-028 Total occupancy: cmd_Xor high for nwords+3 cycles; command-to-interrupt latency is nwords+1 edges.
REQ-029 command is ignored while not IDLE; no restart and no err_Xor.
REQ-030 Address arithmetic is modulo 2**AW; the REQ-021 check guarantees no wrap occurs during a pass.
REQ-031 Never assert both strobes in one cycle; never assert a strobe while cmd_Xor=0.

Reset
REQ-032 On rst at any edge, including mid-pass: state IDLE; all outputs 0 (addresses, select_line, strobes, cmd_Xor, interupt_Xor, err_Xor); no further writes.
REQ-033 rst has priority over command at the same edge.

Verification
REQ-034 start=5, len=100, CMD=6 at E0: E1 A=B=4; E2 w_C=1, C=4, interrupt=1; E3 strobes 0; E4 cmd_Xor=0.
REQ-035 start=5, len=300: E2 w_C@4, A=3; E3 w_D@3, interrupt=1; cmd_Xor high for 5 cycles.
REQ-036 start=7, len=1000 (nwords capped at 3): writes C@6, D@5, C@4 on E2..E4; interrupt on E4 only.
REQ-037 start=1, len=300: err_Xor pulses one cycle; cmd_Xor and strobes stay 0.
REQ-038 rst asserted at E3 during the 3-word pass: all outputs 0 at E3; a new command at E5 produces a clean pass.
REQ-039 CMD=6 reissued at E2 during a pass: ignored; the pass matches REQ-036 timing exactly.

Source files
------------

// File: rtl/seq_xor_engine_if.sv
// Bus bundle for seq_xor_engine: command/operand inputs and the memory-port,
// select and status outputs. Signal names match the original flat port list.
interface seq_xor_engine_if #(
  parameter int unsigned AW = 3,
  parameter int unsigned LW = 10
);
  logic [3:0]    command;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] Data_len_Polynomial;
  logic [AW-1:0] b_adbus_A;
  logic [AW-1:0] b_adbus_B;
  logic          b_w_C;
  logic          b_w_D;
  logic [AW-1:0] b_adbus_C;
  logic [AW-1:0] b_adbus_D;
  logic [2:0]    select_line;
  logic          cmd_Xor;
  logic          interupt_Xor;
  logic          err_Xor;

  modport master (
    output command, start_addr, Data_len_Polynomial,
    input  b_adbus_A, b_adbus_B, b_w_C, b_w_D, b_adbus_C, b_adbus_D,
    input  select_line, cmd_Xor, interupt_Xor, err_Xor
  );

  modport slave (
    input  command, start_addr, Data_len_Polynomial,
    output b_adbus_A, b_adbus_B, b_w_C, b_w_D, b_adbus_C, b_adbus_D,
    output select_line, cmd_Xor, interupt_Xor, err_Xor
  );
endinterface

// File: rtl/seq_xor_engine.sv
// Sequential XOR pass engine: reads nwords memory words downward from
// start_addr-1 and writes them back alternately through result ports C and D.
module seq_xor_engine #(
  parameter int unsigned AW        = 3,
  parameter int unsigned LW        = 10,
  parameter int unsigned WORD_W    = 256,
  parameter int unsigned MAX_WORDS = 3,
  parameter logic [3:0]  CMD_CODE  = 4'h6,
  parameter logic [2:0]  SEL_CODE  = 3'h5
) (
  input logic            clk,
  input logic            rst,
  seq_xor_engine_if.slave bus
);
  localparam int unsigned   WSH   = $clog2(WORD_W);
  localparam logic [LW:0]   MAXW  = (LW+1)'(MAX_WORDS);
  localparam logic [AW-1:0] A_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, READ, DONE, RELEASE} state_t;

  state_t        r_state, w_state;
  logic [AW-1:0] r_start, w_start;
  logic [AW-1:0] r_nwords, w_nwords_q;
  logic [AW-1:0] r_wk, w_wk;
  logic          r_rd_done, w_rd_done;
  logic [AW-1:0] r_ab, w_ab;
  logic [AW-1:0] r_c, w_c;
  logic [AW-1:0] r_d, w_d;
  logic          r_wc, w_wc;
  logic          r_wd, w_wd;
  logic          r_cmd, w_cmd;
  logic          r_irq, w_irq;
  logic          r_err, w_err;
  logic [2:0]    r_sel, w_sel;

  logic [LW:0]   w_nw_full;
  logic [AW-1:0] w_nwords;
  logic [AW-1:0] w_wr_addr;

  always_comb begin
    w_nw_full = (LW+1)'(bus.Data_len_Polynomial >> WSH) + (LW+1)'(1);
    w_nwords  = (w_nw_full > MAXW) ? AW'(MAX_WORDS) : AW'(w_nw_full);
    w_wr_addr = r_start - A_ONE - r_wk;
  end

  // r_rd_done marks that word 0 has been fetched, so writes trail reads by one edge.
  always_comb begin
    w_state    = r_state;
    w_start    = r_start;
    w_nwords_q = r_nwords;
    w_wk       = r_wk;
    w_rd_done  = r_rd_done;
    w_ab       = r_ab;
    w_c        = r_c;
    w_d        = r_d;
    w_wc       = r_wc;
    w_wd       = r_wd;
    w_cmd      = r_cmd;
    w_sel      = r_sel;
    w_irq      = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.command == CMD_CODE) begin
          if (bus.start_addr >= w_nwords) begin
            w_start    = bus.start_addr;
            w_nwords_q = w_nwords;
            w_wk       = '0;
            w_rd_done  = 1'b0;
            w_ab       = bus.start_addr - A_ONE;
            w_cmd      = 1'b1;
            w_sel      = SEL_CODE;
            w_state    = READ;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      READ: begin
        if (!r_rd_done) begin
          w_rd_done = 1'b1;
        end else begin
          if (!r_wk[0]) begin
            w_wc = 1'b1;
            w_wd = 1'b0;
            w_c  = w_wr_addr;
          end else begin
            w_wd = 1'b1;
            w_wc = 1'b0;
            w_d  = w_wr_addr;
          end
          if (r_wk == r_nwords - A_ONE) begin
            w_irq   = 1'b1;
            w_state = DONE;
          end else begin
            w_ab = w_wr_addr - A_ONE;
            w_wk = r_wk + A_ONE;
          end
        end
      end
      DONE: begin
        w_wc    = 1'b0;
        w_wd    = 1'b0;
        w_state = RELEASE;
      end
      RELEASE: begin
        w_cmd   = 1'b0;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_start   <= '0;
      r_nwords  <= '0;
      r_wk      <= '0;
      r_rd_done <= 1'b0;
      r_ab      <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_wc      <= 1'b0;
      r_wd      <= 1'b0;
      r_cmd     <= 1'b0;
      r_irq     <= 1'b0;
      r_err     <= 1'b0;
      r_sel     <= '0;
    end else begin
      r_state   <= w_state;
      r_start   <= w_start;
      r_nwords  <= w_nwords_q;
      r_wk      <= w_wk;
      r_rd_done <= w_rd_done;
      r_ab      <= w_ab;
      r_c       <= w_c;
      r_d       <= w_d;
      r_wc      <= w_wc;
      r_wd      <= w_wd;
      r_cmd     <= w_cmd;
      r_irq     <= w_irq;
      r_err     <= w_err;
      r_sel     <= w_sel;
    end
  end

  assign bus.b_adbus_A    = r_ab;
  assign bus.b_adbus_B    = r_ab;
  assign bus.b_adbus_C    = r_c;
  assign bus.b_adbus_D    = r_d;
  assign bus.b_w_C        = r_wc;
  assign bus.b_w_D        = r_wd;
  assign bus.select_line  = r_sel;
  assign bus.cmd_Xor      = r_cmd;
  assign bus.interupt_Xor = r_irq;
  assign bus.err_Xor      = r_err;
endmodule

// File: tb/tb_seq_xor_engine.sv
// Scoreboard bench for seq_xor_engine: the driver predicts every write/reject
// event and busy-run length; a negedge monitor pops and compares them.
module tb_seq_xor_engine;
  logic clk;
  logic rst;

  seq_xor_engine_if #(.AW(3), .LW(10)) bus ();

  seq_xor_engine #(
    .AW(3), .LW(10), .WORD_W(256), .MAX_WORDS(3),
    .CMD_CODE(4'h6), .SEL_CODE(3'h5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic       wc;
    logic       wd;
    logic [2:0] c;
    logic [2:0] d;
    logic [2:0] a;
    logic [2:0] b;
    logic       irq;
    logic [2:0] sel;
    logic       cmd;
    logic       err;
  } ev_t;

  ev_t sb[$];
  int  occq[$];
  int  checks = 0;
  int  passes = 0;

  // expected values of the registers that hold across passes
  logic [2:0] m_c, m_d, m_a, m_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  int run = 0;
  always @(negedge clk) begin
    ev_t act;
    ev_t want;
    if (bus.b_w_C === 1'b1 || bus.b_w_D === 1'b1 || bus.err_Xor === 1'b1 ||
        bus.interupt_Xor === 1'b1) begin
      act.wc  = bus.b_w_C;
      act.wd  = bus.b_w_D;
      act.c   = bus.b_adbus_C;
      act.d   = bus.b_adbus_D;
      act.a   = bus.b_adbus_A;
      act.b   = bus.b_adbus_B;
      act.irq = bus.interupt_Xor;
      act.sel = bus.select_line;
      act.cmd = bus.cmd_Xor;
      act.err = bus.err_Xor;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL event: got %h, expected no event (t=%0t)", act, $time);
      end else begin
        want = sb.pop_front();
        if (act === want) passes++;
        else $display("FAIL event: got %h, expected %h (t=%0t)", act, want, $time);
      end
    end
    if (rst === 1'b1) begin
      run = 0;
    end else if (bus.cmd_Xor === 1'b1) begin
      run++;
    end else if (run > 0) begin
      checks++;
      if (occq.size() == 0) begin
        $display("FAIL busy_len: got %0d cycles, expected no busy period", run);
      end else begin
        int exp_len;
        exp_len = occq.pop_front();
        if (run == exp_len) passes++;
        else $display("FAIL busy_len: got %0d cycles, expected %0d", run, exp_len);
      end
      run = 0;
    end
  end

  function automatic logic [3:0] non_cmd();
    int c;
    c = $urandom_range(0, 14);
    if (c >= 6) c++;
    return 4'(c);
  endfunction

  task automatic check_all_zero(input string name);
    logic [27:0] v;
    v = {bus.b_adbus_A, bus.b_adbus_B, bus.b_adbus_C, bus.b_adbus_D, bus.b_w_C,
         bus.b_w_D, bus.select_line, bus.cmd_Xor, bus.interupt_Xor, bus.err_Xor,
         6'b0};
    checks++;
    if (v === '0) passes++;
    else $display("FAIL %s: outputs got %h, expected all zero", name, v);
  endtask

  task automatic model_reset();
    m_c = '0; m_d = '0; m_a = '0; m_sel = '0;
  endtask

  // Issue one XOR command; inject=1 keeps CMD asserted while busy; abort=1
  // applies reset at the third edge of the pass (3-word passes only).
  task automatic issue(input logic [2:0] st, input logic [9:0] len,
                       input bit inject, input bit abort);
    int  n;
    ev_t e;
    bit  done;
    n = int'(len) / 256 + 1;
    if (n > 3) n = 3;
    if (int'(st) >= n) begin
      for (int k = 0; k < n; k++) begin
        e = '0;
        if (k % 2 == 0) begin
          e.wc = 1'b1;
          m_c  = 3'(int'(st) - 1 - k);
        end else begin
          e.wd = 1'b1;
          m_d  = 3'(int'(st) - 1 - k);
        end
        e.c   = m_c;
        e.d   = m_d;
        e.a   = (k < n - 1) ? 3'(int'(st) - 2 - k) : 3'(int'(st) - n);
        e.b   = e.a;
        e.irq = (k == n - 1);
        e.sel = 3'h5;
        e.cmd = 1'b1;
        sb.push_back(e);
      end
      occq.push_back(n + 3);
      m_a   = 3'(int'(st) - n);
      m_sel = 3'h5;
    end else begin
      e     = '0;
      e.c   = m_c;
      e.d   = m_d;
      e.a   = m_a;
      e.b   = m_a;
      e.sel = m_sel;
      e.err = 1'b1;
      sb.push_back(e);
    end
    bus.command = 4'h6;
    bus.start_addr = st;
    bus.Data_len_Polynomial = len;
    @(posedge clk); #1;
    bus.command = 4'h0;
    if (abort) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_mid_pass");
      rst = 1'b0;
      sb.delete();
      occq.delete();
      model_reset();
    end else begin
      done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (bus.cmd_Xor === 1'b1) begin
          if (inject || $urandom_range(0, 3) == 0) begin
            bus.command = 4'h6;
            bus.start_addr = 3'($urandom_range(0, 7));
            bus.Data_len_Polynomial = 10'($urandom_range(0, 1023));
          end else begin
            bus.command = non_cmd();
          end
        end else begin
          bus.command = 4'h0;
          if (sb.size() == 0 && occq.size() == 0) begin
            done = 1'b1;
            break;
          end
        end
      end
      checks++;
      if (done) passes++;
      else $display("FAIL completion: pass at start=%0d len=%0d did not drain within 20 cycles", st, len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.command = 4'h0;
    bus.start_addr = '0;
    bus.Data_len_Polynomial = '0;
    model_reset();
    @(posedge clk); #1;
    bus.command = 4'h6;
    bus.start_addr = 3'd7;
    @(posedge clk); #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    bus.command = 4'h0;
    @(posedge clk); #1;

    issue(3'd5, 10'd100,  0, 0);
    issue(3'd5, 10'd300,  0, 0);
    issue(3'd7, 10'd1000, 0, 0);
    issue(3'd1, 10'd300,  0, 0);
    issue(3'd7, 10'd1000, 1, 0);
    issue(3'd0, 10'd0,    0, 0);
    issue(3'd2, 10'd511,  0, 0);
    issue(3'd2, 10'd512,  0, 0);
    issue(3'd1, 10'd255,  0, 0);
    issue(3'd7, 10'd1000, 0, 1);
    @(posedge clk); #1;
    issue(3'd7, 10'd1000, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] st;
      logic [9:0] len;
      bit         ab;
      repeat ($urandom_range(0, 2)) begin
        bus.command = non_cmd();
        bus.start_addr = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
      end
      st  = 3'($urandom_range(0, 7));
      len = 10'($urandom_range(0, 1023));
      ab  = (st >= 3'd3) && (len >= 10'd512) && ($urandom_range(0, 3) == 0);
      issue(st, len, 1'($urandom_range(0, 1)), ab);
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0 && occq.size() == 0) passes++;
    else $display("FAIL leftover: got %0d events and %0d busy periods pending, expected 0 and 0",
                  sb.size(), occq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
